// File: rtl/rename_issue_ctrl.sv
// Issue sequencer: 2-entry decode FIFO, in-order ROB tag allocation,
// rename/issue strobe generation, ROB occupancy tracking and flush recovery.
module rename_issue_ctrl #(
    parameter int unsigned ROB_SZ_LOG = 4,
    parameter int unsigned INFO_W     = 64,
    parameter int unsigned FLUSH_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic                  dec_rs1_hv,
    input  logic                  dec_rs2_hv,
    input  logic                  dec_rd_hv,
    input  logic [4:0]            dec_rs1,
    input  logic [4:0]            dec_rs2,
    input  logic [4:0]            dec_rd,
    input  logic [INFO_W-1:0]     dec_info,
    output logic                  run_add,
    output logic                  rs1_hv,
    output logic [4:0]            rs1,
    output logic                  rs2_hv,
    output logic [4:0]            rs2,
    output logic                  rd_hv,
    output logic [4:0]            rd,
    output logic [ROB_SZ_LOG:0]   tail,
    output logic [INFO_W-1:0]     iss_info,
    input  logic                  rs_full,
    input  logic                  commit_valid,
    input  logic                  reset,
    output logic [ROB_SZ_LOG:0]   rob_count
);

    localparam int unsigned TAG_W = ROB_SZ_LOG + 1;
    localparam logic [TAG_W-1:0] ROB_CAP = TAG_W'(1 << ROB_SZ_LOG);
    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

    typedef struct packed {
        logic              rs1_hv;
        logic [4:0]        rs1;
        logic              rs2_hv;
        logic [4:0]        rs2;
        logic              rd_hv;
        logic [4:0]        rd;
        logic [INFO_W-1:0] info;
    } dec_entry_t;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    dec_entry_t       fifo_q [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] rob_cnt_q, rob_cnt_d;

    logic       flush;
    logic       run_ok;
    logic       push;
    logic       commit;
    dec_entry_t wr_entry;
    dec_entry_t iss_entry;

    // Handshake and issue decisions; a flush cycle drops push, issue and commit.
    always_comb begin
        flush     = rdy & reset;
        run_ok    = rdy & (state_q == ST_RUN) & ~reset;
        dec_ready = run_ok & (fifo_cnt_q != 2'd2);
        run_add   = run_ok & (fifo_cnt_q != 2'd0) & ~rs_full & (rob_cnt_q < ROB_CAP);
        push      = dec_valid & dec_ready;
        commit    = rdy & ~reset & commit_valid & (rob_cnt_q != '0);
    end

    always_comb begin
        wr_entry = '{rs1_hv: dec_rs1_hv, rs1: dec_rs1, rs2_hv: dec_rs2_hv, rs2: dec_rs2,
                     rd_hv: dec_rd_hv, rd: dec_rd, info: dec_info};
        iss_entry = run_add ? fifo_q[rd_ptr_q] : '0;
        rs1_hv    = iss_entry.rs1_hv;
        rs1       = iss_entry.rs1;
        rs2_hv    = iss_entry.rs2_hv;
        rs2       = iss_entry.rs2;
        rd_hv     = iss_entry.rd_hv;
        rd        = iss_entry.rd;
        iss_info  = iss_entry.info;
        tail      = tag_q;
        rob_count = rob_cnt_q;
    end

    // Next-state: flush wins, otherwise advance only on rdy cycles.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        tag_d       = tag_q;
        rob_cnt_d   = rob_cnt_q;
        if (flush) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = 3'(FLUSH_CYC);
            rd_ptr_d    = 1'b0;
            wr_ptr_d    = 1'b0;
            fifo_cnt_d  = 2'd0;
            tag_d       = TAG_ONE;
            rob_cnt_d   = '0;
        end else if (rdy) begin
            if (state_q == ST_FLUSH) begin
                if (flush_cnt_q <= 3'd1) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 3'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (run_add) begin
                rd_ptr_d = ~rd_ptr_q;
                tag_d    = (tag_q == ROB_CAP) ? TAG_ONE : tag_q + TAG_ONE;
            end
            fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(run_add);
            rob_cnt_d  = rob_cnt_q + TAG_W'(run_add) - TAG_W'(commit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            tag_q       <= TAG_ONE;
            rob_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            tag_q       <= tag_d;
            rob_cnt_q   <= rob_cnt_d;
        end
    end

    // Payload storage needs no reset; validity is carried by fifo_cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_rename_issue_ctrl.sv
// Directed, table-driven bench for rename_issue_ctrl (default parameters).
module tb_rename_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, dec_valid, dec_ready;
    logic        dec_rs1_hv, dec_rs2_hv, dec_rd_hv;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [63:0] dec_info;
    logic        run_add, rs1_hv, rs2_hv, rd_hv;
    logic [4:0]  rs1, rs2, rd;
    logic [4:0]  tail, rob_count;
    logic [63:0] iss_info;
    logic        rs_full, commit_valid, reset;

    int n_chk  = 0;
    int n_fail = 0;

    rename_issue_ctrl #(.ROB_SZ_LOG(4), .INFO_W(64), .FLUSH_CYC(1)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1_hv(dec_rs1_hv), .dec_rs2_hv(dec_rs2_hv), .dec_rd_hv(dec_rd_hv),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_info(dec_info),
        .run_add(run_add),
        .rs1_hv(rs1_hv), .rs1(rs1), .rs2_hv(rs2_hv), .rs2(rs2), .rd_hv(rd_hv), .rd(rd),
        .tail(tail), .iss_info(iss_info),
        .rs_full(rs_full), .commit_valid(commit_valid), .reset(reset),
        .rob_count(rob_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, rdy, dv;
        logic [4:0] rd;
        logic       rsf, cm, rf;
        logic       edr, era;
        logic [4:0] etail, ecnt, erd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int r, input int y, input int dv, input int rdi,
                                input int rsf, input int cm, input int rf,
                                input int edr, input int era, input int et,
                                input int ec, input int erd);
        vec_t v;
        v.rst = 1'(r);   v.rdy = 1'(y);   v.dv = 1'(dv);  v.rd = 5'(rdi);
        v.rsf = 1'(rsf); v.cm = 1'(cm);   v.rf = 1'(rf);
        v.edr = 1'(edr); v.era = 1'(era); v.etail = 5'(et); v.ecnt = 5'(ec);
        v.erd = 5'(erd);
        return v;
    endfunction

    function automatic logic [63:0] info_of(input logic [4:0] r);
        return {32'hC0DE_0000, 27'd0, r};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then check before the rising edge.
    task automatic step(input vec_t v, input int idx);
        logic [81:0] exp_pl;
        @(negedge clk);
        rst = v.rst; rdy = v.rdy; dec_valid = v.dv; rs_full = v.rsf;
        commit_valid = v.cm; reset = v.rf;
        dec_rd = v.rd; dec_rs1 = 5'(v.rd + 5'd1); dec_rs2 = 5'(v.rd + 5'd2);
        dec_info = info_of(v.rd);
        #1;
        exp_pl = v.era ? {1'b1, 5'(v.erd + 5'd1), 1'b1, 5'(v.erd + 5'd2), 1'b1, v.erd,
                          info_of(v.erd)} : '0;
        chk("dec_ready", idx, 128'(dec_ready), 128'(v.edr));
        chk("run_add",   idx, 128'(run_add),   128'(v.era));
        chk("tail",      idx, 128'(tail),      128'(v.etail));
        chk("rob_count", idx, 128'(rob_count), 128'(v.ecnt));
        chk("payload",   idx,
            128'({rs1_hv, rs1, rs2_hv, rs2, rd_hv, rd, iss_info}), 128'(exp_pl));
    endtask

    initial begin
        //            rst rdy dv rd rsf cm rf | edr era tail cnt erd
        // Back-to-back push of three, issue on the following cycles.
        vecs.push_back(mk(0,1,1, 5,0,0,0, 1,0,1,0,0));
        vecs.push_back(mk(0,1,1, 6,0,0,0, 1,1,1,0,5));
        vecs.push_back(mk(0,1,1, 7,0,0,0, 1,1,2,1,6));
        vecs.push_back(mk(0,1,0, 0,0,0,0, 1,1,3,2,7));
        vecs.push_back(mk(0,1,0, 0,0,0,0, 1,0,4,3,0));
        vecs.push_back(mk(1,1,0, 0,0,0,0, 1,0,4,3,0));
        // rs_full backpressure fills the FIFO; no pass-through while full.
        vecs.push_back(mk(0,1,1, 8,1,0,0, 1,0,1,0,0));
        vecs.push_back(mk(0,1,1, 9,1,0,0, 1,0,1,0,0));
        vecs.push_back(mk(0,1,1,10,1,0,0, 0,0,1,0,0));
        vecs.push_back(mk(0,1,1,10,0,0,0, 0,1,1,0,8));
        vecs.push_back(mk(0,1,0, 0,0,0,0, 1,1,2,1,9));
        vecs.push_back(mk(0,1,0, 0,0,0,0, 1,0,3,2,0));
        // Issue+commit together at rob_count=4, then drain and underflow guard.
        vecs.push_back(mk(0,1,1,11,0,0,0, 1,0,3,2,0));
        vecs.push_back(mk(0,1,1,12,0,0,0, 1,1,3,2,11));
        vecs.push_back(mk(0,1,1,13,0,0,0, 1,1,4,3,12));
        vecs.push_back(mk(0,1,0, 0,0,1,0, 1,1,5,4,13));
        vecs.push_back(mk(0,1,0, 0,0,0,0, 1,0,6,4,0));
        vecs.push_back(mk(0,1,0, 0,0,1,0, 1,0,6,4,0));
        vecs.push_back(mk(0,1,0, 0,0,1,0, 1,0,6,3,0));
        vecs.push_back(mk(0,1,0, 0,0,1,0, 1,0,6,2,0));
        vecs.push_back(mk(0,1,0, 0,0,1,0, 1,0,6,1,0));
        vecs.push_back(mk(0,1,0, 0,0,1,0, 1,0,6,0,0));
        vecs.push_back(mk(0,1,0, 0,0,0,0, 1,0,6,0,0));
        // Build rob_count=5, tail=6, two buffered, then flush.
        vecs.push_back(mk(1,1,0, 0,0,0,0, 1,0,6,0,0));
        vecs.push_back(mk(0,1,1, 1,0,0,0, 1,0,1,0,0));
        vecs.push_back(mk(0,1,1, 2,0,0,0, 1,1,1,0,1));
        vecs.push_back(mk(0,1,1, 3,0,0,0, 1,1,2,1,2));
        vecs.push_back(mk(0,1,1, 4,0,0,0, 1,1,3,2,3));
        vecs.push_back(mk(0,1,1, 5,0,0,0, 1,1,4,3,4));
        vecs.push_back(mk(0,1,1,20,0,0,0, 1,1,5,4,5));
        vecs.push_back(mk(0,1,1,21,1,0,0, 1,0,6,5,0));
        vecs.push_back(mk(0,1,1,22,0,1,1, 0,0,6,5,0));
        vecs.push_back(mk(0,1,1,23,0,0,0, 0,0,1,0,0));
        vecs.push_back(mk(0,1,1,24,0,0,0, 1,0,1,0,0));
        vecs.push_back(mk(0,1,0, 0,0,0,0, 1,1,1,0,24));
        // Flush asserted again while already flushing reloads the counter.
        vecs.push_back(mk(0,1,0, 0,0,0,1, 0,0,2,1,0));
        vecs.push_back(mk(0,1,0, 0,0,0,1, 0,0,1,0,0));
        vecs.push_back(mk(0,1,1,25,0,0,0, 0,0,1,0,0));
        vecs.push_back(mk(0,1,1,25,0,0,0, 1,0,1,0,0));
        vecs.push_back(mk(0,1,0, 0,0,0,0, 1,1,1,0,25));
        // rdy pause mid-stream (commit and flush ignored), resume, then rst with rdy low.
        vecs.push_back(mk(0,1,1,26,0,0,0, 1,0,2,1,0));
        vecs.push_back(mk(0,1,1,27,0,0,0, 1,1,2,1,26));
        vecs.push_back(mk(0,0,1,28,0,1,0, 0,0,3,2,0));
        vecs.push_back(mk(0,0,1,28,0,1,0, 0,0,3,2,0));
        vecs.push_back(mk(0,0,1,28,0,1,1, 0,0,3,2,0));
        vecs.push_back(mk(0,1,1,28,0,0,0, 1,1,3,2,27));
        vecs.push_back(mk(0,1,1,29,0,0,0, 1,1,4,3,28));
        vecs.push_back(mk(1,0,1,30,0,0,0, 0,0,5,4,0));
        vecs.push_back(mk(0,1,0, 0,0,0,0, 1,0,1,0,0));
        vecs.push_back(mk(1,1,0, 0,0,0,0, 1,0,1,0,0));

        rst = 1'b1; rdy = 1'b1; dec_valid = 1'b0; rs_full = 1'b0;
        commit_valid = 1'b0; reset = 1'b0;
        dec_rs1_hv = 1'b1; dec_rs2_hv = 1'b1; dec_rd_hv = 1'b1;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_info = '0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) step(vecs[i], i);

        // Fill the ROB: 16 issues with tags 1..16, 17th stalls until a commit lands.
        step(mk(0,1,1, 0,0,0,0, 1,0,1,0,0), 100);
        for (int k = 1; k <= 16; k++) begin
            step(mk(0,1,1,k,0,0,0, 1,1,k,k-1,k-1), 100 + k);
        end
        step(mk(0,1,1,17,0,0,0, 1,0,1,16,0), 117);
        step(mk(0,1,1,18,0,1,0, 0,0,1,16,0), 118);
        step(mk(0,1,0, 0,0,0,0, 0,1,1,15,16), 119);
        step(mk(0,1,0, 0,0,0,0, 1,0,2,16,0), 120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
